// File: rtl/fifo_byte_packer_if.sv
// Handshake bundle between the byte packer, its upstream standard-mode FIFO and the
// downstream consumer of packed words.
interface fifo_byte_packer_if #(
  parameter int InWidth = 8,
  parameter int Lanes   = 4
);

  logic                       FifoEmpty;
  logic                       FifoRead;
  logic [InWidth-1:0]         FifoDout;
  logic                       FifoValid;
  logic                       Flush;
  logic [InWidth*Lanes-1:0]   OutData;
  logic [Lanes-1:0]           OutByteEn;
  logic                       OutValid;
  logic                       OutReady;
  logic                       Busy;
  logic                       Overrun;

  modport master (
    input  FifoEmpty, FifoDout, FifoValid, Flush, OutReady,
    output FifoRead, OutData, OutByteEn, OutValid, Busy, Overrun
  );

  modport slave (
    output FifoEmpty, FifoDout, FifoValid, Flush, OutReady,
    input  FifoRead, OutData, OutByteEn, OutValid, Busy, Overrun
  );

endinterface

// File: rtl/fifo_byte_packer.sv
// Packs InWidth-bit words read from a standard-mode FIFO into Lanes-wide output words,
// with an on-demand flush of partial words and a sticky overrun flag.
module fifo_byte_packer #(
  parameter int InWidth = 8,
  parameter int Lanes   = 4
) (
  input logic                Clk,
  input logic                Reset,
  fifo_byte_packer_if.master bus
);

  localparam int              CntW    = $clog2(Lanes + 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(Lanes);

  typedef enum logic {StFill, StFlush} state_t;

  state_t                        state;
  state_t                        nextState;
  logic [CntW-1:0]               cnt;
  logic                          pending;
  logic [Lanes-1:0][InWidth-1:0] asmData;
  logic [Lanes-1:0][InWidth-1:0] loadData;
  logic [Lanes-1:0]              loadMask;
  logic [InWidth*Lanes-1:0]      outData;
  logic [Lanes-1:0]              outByteEn;
  logic                          outValid;
  logic                          overrun;
  logic                          fifoRead;
  logic                          slotFree;
  logic                          capture;
  logic                          overrunHit;
  logic                          load;
  logic [CntW:0]                 inFlight;

  // Reads in flight count against free lanes so a returning word always has a slot.
  assign inFlight   = {1'b0, cnt} + {{CntW{1'b0}}, pending};
  assign fifoRead   = ~Reset & (state == StFill) & ~bus.FifoEmpty
                    & (inFlight < (CntW+1)'(Lanes));
  assign slotFree   = ~outValid | bus.OutReady;
  assign capture    = bus.FifoValid && (cnt < FullCnt);
  assign overrunHit = bus.FifoValid && (cnt == FullCnt);

  always_comb begin
    nextState = state;
    load      = 1'b0;
    case (state)
      StFill: begin
        load = (cnt == FullCnt) && slotFree;
        if (bus.Flush) nextState = StFlush;
      end
      StFlush: begin
        if (!pending) begin
          if (cnt == '0) begin
            nextState = StFill;
          end else if (slotFree) begin
            load      = 1'b1;
            nextState = StFill;
          end
        end
      end
      default: nextState = StFill;
    endcase
  end

  // Lanes at or above cnt may hold stale bytes from an earlier word; blank them on load.
  always_comb begin
    for (int i = 0; i < Lanes; i++) begin
      loadMask[i] = (CntW'(i) < cnt);
      loadData[i] = loadMask[i] ? asmData[i] : '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) state <= StFill;
    else       state <= nextState;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt       <= '0;
      pending   <= 1'b0;
      outData   <= '0;
      outByteEn <= '0;
      outValid  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      pending <= fifoRead;
      if (overrunHit) overrun <= 1'b1;
      if (load)         cnt <= '0;
      else if (capture) cnt <= cnt + 1'b1;
      if (load) begin
        outData   <= loadData;
        outByteEn <= loadMask;
        outValid  <= 1'b1;
      end else if (bus.OutReady) begin
        outValid  <= 1'b0;
      end
    end
  end

  always_ff @(posedge Clk) begin
    for (int i = 0; i < Lanes; i++) begin
      if (capture && (cnt == CntW'(i))) asmData[i] <= bus.FifoDout;
    end
  end

  assign bus.FifoRead  = fifoRead;
  assign bus.OutData   = outData;
  assign bus.OutByteEn = outByteEn;
  assign bus.OutValid  = outValid;
  assign bus.Overrun   = overrun;
  assign bus.Busy      = (state == StFlush) | (cnt != '0) | pending | outValid;

endmodule
